// File: rtl/mem_stage_dport.sv
// Memory-stage data-port controller: issues load/store requests to the data
// cache, holds captured load data until the pipeline advances, and latches halt.
module mem_stage_dport #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              req_valid,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic              halt_in,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] load_data,
  output logic              mem_ready,
  output logic              addr_misalign,
  output logic              halt_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  load_q, load_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               halt_q, halt_d;

  logic               act;
  logic               hit;
  logic               retire_halt;

  // Enables are gated by nRST so they fall the instant reset asserts,
  // even if the EX/MEM register still presents a request.
  always_comb begin
    act           = nRST & req_valid & (req_ren | req_wen) &
                    ((state_q == IDLE) | (state_q == ACCESS));
    hit           = act & dhit;
    dmemWEN       = act & req_wen;
    dmemREN       = act & req_ren & ~req_wen;
    dmemaddr      = {req_addr[WORD_W-1:2], 2'b00};
    dmemstore     = req_wdata;
    addr_misalign = act & (req_addr[1:0] != 2'b00);
    load_data     = hit ? dmemload : load_q;
    halt_out      = halt_q;
    stall_cnt     = stall_cnt_q;

    case (state_q)
      HALTED:  mem_ready = 1'b0;
      HOLD:    mem_ready = 1'b1;
      default: mem_ready = act ? dhit : 1'b1;
    endcase

    retire_halt = req_valid & halt_in & mem_ready & ihit;
  end

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    stall_cnt_d = stall_cnt_q;
    halt_d      = halt_q;

    if ((state_q == ACCESS) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (retire_halt) begin
      state_d = HALTED;
      halt_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCESS: begin
          if (hit) begin
            if (ihit) begin
              state_d = IDLE;
            end else begin
              state_d = HOLD;
              load_d  = dmemload;
            end
          end else if (act) begin
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (ihit) state_d = IDLE;
        end
        default: state_d = HALTED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      load_q      <= '0;
      stall_cnt_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
      halt_q      <= halt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_dport.sv
// Bench for mem_stage_dport: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of the port.
module tb_mem_stage_dport;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ihit, dhit, req_valid, req_ren, req_wen, halt_in;
  logic [WORD_W-1:0] req_addr, req_wdata, dmemload;
  logic              dmemREN, dmemWEN, mem_ready, addr_misalign, halt_out;
  logic [WORD_W-1:0] dmemaddr, dmemstore, load_data;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: an outstanding miss, a held word waiting for ihit, halted.
  bit          m_wait, m_held, m_halted;
  logic [31:0] m_word;
  int          m_stall;

  mem_stage_dport #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .halt_in(halt_in),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .load_data(load_data),
    .mem_ready(mem_ready), .addr_misalign(addr_misalign),
    .halt_out(halt_out), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_held = 0; m_halted = 0; m_word = '0; m_stall = 0;
  endtask

  function automatic bit model_act();
    return req_valid && (req_ren || req_wen) && !m_held && !m_halted;
  endfunction

  function automatic bit model_ready();
    if (m_halted) return 1'b0;
    if (m_held) return 1'b1;
    return model_act() ? dhit : 1'b1;
  endfunction

  // Let combinational outputs settle, then compare all of them with the model.
  task automatic settle_check(input string ph);
    bit act;
    #2;
    act = model_act();
    check({ph, ".ren"},   32'(dmemREN),       32'(act && req_ren && !req_wen));
    check({ph, ".wen"},   32'(dmemWEN),       32'(act && req_wen));
    check({ph, ".addr"},  dmemaddr,           req_addr & 32'hFFFF_FFFC);
    check({ph, ".store"}, dmemstore,          req_wdata);
    check({ph, ".ldata"}, load_data,          (act && dhit) ? dmemload : m_word);
    check({ph, ".ready"}, 32'(mem_ready),     32'(model_ready()));
    check({ph, ".misal"}, 32'(addr_misalign), 32'(act && (req_addr % 4 != 0)));
    check({ph, ".halt"},  32'(halt_out),      32'(m_halted));
    check({ph, ".stall"}, 32'(stall_cnt),     32'(m_stall));
  endtask

  // Advance one clock and apply the rules to the model using this cycle's inputs.
  task automatic tick();
    bit act, rdy;
    @(posedge CLK);
    act = model_act();
    rdy = model_ready();
    if (m_wait && m_stall < CNT_MAX) m_stall++;
    if (req_valid && halt_in && rdy && ihit) begin
      m_halted = 1; m_wait = 0; m_held = 0;
    end else if (m_held) begin
      if (ihit) m_held = 0;
    end else if (act) begin
      if (dhit) begin
        m_wait = 0;
        if (!ihit) begin m_held = 1; m_word = dmemload; end
      end else begin
        m_wait = 1;
      end
    end else begin
      m_wait = 0;
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; checks its immediate effect.
  task automatic do_reset(input string ph);
    nRST = 1'b0;
    #1;
    check({ph, ".rst_ren"},   32'(dmemREN),   32'd0);
    check({ph, ".rst_wen"},   32'(dmemWEN),   32'd0);
    check({ph, ".rst_stall"}, 32'(stall_cnt), 32'd0);
    check({ph, ".rst_halt"},  32'(halt_out),  32'd0);
    check({ph, ".rst_ldata"}, load_data,      32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_ren = 0; req_wen = 0; halt_in = 0;
    dhit = 0; ihit = 1; req_addr = '0; req_wdata = '0; dmemload = '0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // 1: reset state and a no-op instruction
    req_valid = 1; ihit = 1;
    settle_check("t1");
    check("t1.ready1", 32'(mem_ready), 32'd1);
    check("t1.stall0", 32'(stall_cnt), 32'd0);
    tick();

    // 2: load with dhit three cycles after issue
    req_ren = 1; req_addr = 32'h0000_0104; dmemload = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      settle_check("t2.wait");
      check("t2.ren_wait", 32'(dmemREN), 32'd1);
      tick();
    end
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    settle_check("t2.hit");
    check("t2.ldata_hit", load_data, 32'hDEAD_BEEF);
    check("t2.ren_hit", 32'(dmemREN), 32'd1);
    tick();
    req_valid = 0; req_ren = 0; dhit = 0;
    settle_check("t2.after");
    check("t2.stall3", 32'(stall_cnt), 32'd3);
    tick();

    // 3: dhit before ihit -> HOLD
    req_valid = 1; req_ren = 1; req_addr = 32'h0000_0040; ihit = 0;
    for (int c = 0; c < 6; c++) begin
      dhit = (c == 2);
      dmemload = (c == 2) ? 32'h1234_5678 : 32'h0BAD_0000 + 32'(c);
      ihit = (c == 5);
      settle_check("t3");
      if (c >= 3) begin
        check("t3.ren_hold", 32'(dmemREN), 32'd0);
        check("t3.ldata_hold", load_data, 32'h1234_5678);
        check("t3.ready_hold", 32'(mem_ready), 32'd1);
      end
      tick();
    end
    req_valid = 0; req_ren = 0; dhit = 0; ihit = 1;
    settle_check("t3.idle");
    tick();

    // 4: misaligned store, then conflicting enables resolve as a store
    req_valid = 1; req_wen = 1; req_addr = 32'h0000_0203; req_wdata = 32'hCAFE_0001; dhit = 1;
    settle_check("t4.st");
    check("t4.addr", dmemaddr, 32'h0000_0200);
    check("t4.misal", 32'(addr_misalign), 32'd1);
    check("t4.store", dmemstore, 32'hCAFE_0001);
    tick();
    req_ren = 1; req_addr = 32'h0000_0200;
    settle_check("t4.both");
    check("t4.both_wen", 32'(dmemWEN), 32'd1);
    check("t4.both_ren", 32'(dmemREN), 32'd0);
    tick();

    // 5: halt retirement
    req_ren = 0; req_wen = 0; halt_in = 1; dhit = 0; ihit = 1;
    settle_check("t5.halt");
    tick();
    halt_in = 0; req_ren = 1;
    for (int c = 0; c < 3; c++) begin
      dhit = c[0];
      settle_check("t5.halted");
      check("t5.halt_out", 32'(halt_out), 32'd1);
      check("t5.ren_off", 32'(dmemREN), 32'd0);
      check("t5.ready0", 32'(mem_ready), 32'd0);
      tick();
    end
    #2;
    do_reset("t5");
    settle_check("t5.post");

    // 6: reset in the middle of an access
    tick();
    req_valid = 1; req_ren = 1; req_addr = 32'h0000_0300; dhit = 0;
    settle_check("t6.a"); tick();
    settle_check("t6.b"); tick();
    #2;
    do_reset("t6");
    settle_check("t6.fresh0"); tick();
    dhit = 1; dmemload = 32'h0F0F_A5A5;
    settle_check("t6.fresh1");
    check("t6.ldata", load_data, 32'h0F0F_A5A5);
    tick();

    // stall counter saturation
    dhit = 0;
    for (int c = 0; c < CNT_MAX + 4; c++) begin
      settle_check("sat"); tick();
    end
    check("sat.max", 32'(stall_cnt), 32'(CNT_MAX));
    dhit = 1;
    settle_check("sat.end"); tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!m_wait && !m_held) begin
        req_valid = ($urandom_range(0, 3) != 0);
        halt_in   = ($urandom_range(0, 49) == 0);
        req_ren   = halt_in ? 1'b0 : 1'($urandom_range(0, 1));
        req_wen   = halt_in ? 1'b0 : 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      dhit     = 1'($urandom_range(0, 1));
      ihit     = ($urandom_range(0, 3) != 0);
      dmemload = $urandom;
      settle_check("rnd");
      if (m_halted && $urandom_range(0, 5) == 0) do_reset("rnd");
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
